// File: rtl/alu_pkg.sv
// Shared op encodings and controller state encoding for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic               busy_q,   busy_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    // Next-state for one shift-add step; counter wraps to zero on the last step.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = {CW{1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = {(2*WIDTH){1'b0}};
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == LAST_ITER) begin
                busy_d = 1'b0;
                cnt_d  = {CW{1'b0}};
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LAST_ITER);
    assign prod = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops plus a sequential multiply.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             unsig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluout,
    output logic             compout,
    output logic             overflow
);

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    logic [1:0]       state_q,     state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] aluout_q,    aluout_d;
    logic             compout_q,   compout_d;
    logic             overflow_q,  overflow_d;
    logic             cmp_pend_q,  cmp_pend_d;
    logic             sgn_pend_q,  sgn_pend_d;
    logic             neg_q,       neg_d;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic               lt_u_s, lt_s;
    logic [WIDTH-1:0]   res_s;
    logic               ovf_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic               in_ready_s, mul_start_s;
    logic               mul_busy_s, mul_done_s;
    logic [2*WIDTH-1:0] prod_s, full_s;
    logic               mul_ovf_s;

    assign sum_s   = {1'b0, a} + {1'b0, b};
    assign diff_s  = a - b;
    assign lt_u_s  = (a < b);
    assign lt_s    = unsig ? ($signed(a) < $signed(b)) : lt_u_s;
    assign a_mag_s = (unsig && a[WIDTH-1]) ? (~a + ONE_W) : a;
    assign b_mag_s = (unsig && b[WIDTH-1]) ? (~b + ONE_W) : b;

    // Single-cycle datapath; unsig=1 selects signed semantics.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        ovf_s = 1'b0;
        case (op)
            OP_AND: res_s = a & b;
            OP_OR:  res_s = a | b;
            OP_NOR: res_s = ~(a | b);
            OP_XOR: res_s = a ^ b;
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                ovf_s = unsig ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]))
                              : sum_s[WIDTH];
            end
            OP_SUB: begin
                res_s = diff_s;
                ovf_s = unsig ? ((a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]))
                              : lt_u_s;
            end
            OP_SLT: res_s = {{(WIDTH-1){1'b0}}, lt_s};
            default: begin
                res_s = {WIDTH{1'b0}};
                ovf_s = 1'b0;
            end
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start_s),
        .a_mag (a_mag_s),
        .b_mag (b_mag_s),
        .busy  (mul_busy_s),
        .done  (mul_done_s),
        .prod  (prod_s)
    );

    // Signed overflow: the upper WIDTH+1 bits of the product must be a pure sign extension.
    assign full_s    = neg_q ? (~prod_s + ONE_2W) : prod_s;
    assign mul_ovf_s = sgn_pend_q ? ~((&full_s[2*WIDTH-1:WIDTH-1]) | ~(|full_s[2*WIDTH-1:WIDTH-1]))
                                  : (|full_s[2*WIDTH-1:WIDTH]);

    // Handshake and sequencing controller.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        aluout_d    = aluout_q;
        compout_d   = compout_q;
        overflow_d  = overflow_q;
        cmp_pend_d  = cmp_pend_q;
        sgn_pend_d  = sgn_pend_q;
        neg_d       = neg_q;
        in_ready_s  = 1'b0;
        mul_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s = !rst && !(out_valid_q && !out_ready);
                if (in_valid && in_ready_s) begin
                    if (op == OP_MUL) begin
                        mul_start_s = 1'b1;
                        state_d     = ST_MUL;
                        cmp_pend_d  = lt_s;
                        sgn_pend_d  = unsig;
                        neg_d       = unsig && (a[WIDTH-1] ^ b[WIDTH-1]);
                    end else begin
                        out_valid_d = 1'b1;
                        aluout_d    = res_s;
                        compout_d   = lt_s;
                        overflow_d  = ovf_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d = ST_DONE;
                end else if (!mul_busy_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    aluout_d    = full_s[WIDTH-1:0];
                    compout_d   = cmp_pend_q;
                    overflow_d  = mul_ovf_s;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            aluout_q    <= {WIDTH{1'b0}};
            compout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            cmp_pend_q  <= 1'b0;
            sgn_pend_q  <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            aluout_q    <= aluout_d;
            compout_q   <= compout_d;
            overflow_q  <= overflow_d;
            cmp_pend_q  <= cmp_pend_d;
            sgn_pend_q  <= sgn_pend_d;
            neg_q       <= neg_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign aluout    = aluout_q;
    assign compout   = compout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32 plus a WIDTH=8 instance).
module tb_alu_mc;

    localparam logic [2:0] T_AND = 3'b000;
    localparam logic [2:0] T_OR  = 3'b001;
    localparam logic [2:0] T_ADD = 3'b010;
    localparam logic [2:0] T_MUL = 3'b011;
    localparam logic [2:0] T_NOR = 3'b100;
    localparam logic [2:0] T_XOR = 3'b101;
    localparam logic [2:0] T_SUB = 3'b110;
    localparam logic [2:0] T_SLT = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, unsig = 1'b0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic [2:0]  op = 3'd0;
    logic        in_ready, out_valid, compout, overflow;
    logic [31:0] aluout;

    logic        in_valid8 = 1'b0, unsig8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic [2:0]  op8 = 3'd0;
    logic        in_ready8, out_valid8, compout8, overflow8;
    logic [7:0]  aluout8;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .unsig(unsig),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluout(aluout), .compout(compout), .overflow(overflow)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .unsig(unsig8),
        .out_valid(out_valid8), .out_ready(1'b1),
        .aluout(aluout8), .compout(compout8), .overflow(overflow8)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on the 32-bit instance with out_ready high; checks latency and results.
    task automatic run_vec(input string tag, input logic [2:0] op_i, input logic [31:0] a_i,
                           input logic [31:0] b_i, input logic un_i, input logic [31:0] exp_r,
                           input logic exp_c, input logic exp_o);
        int lat;
        @(negedge clk);
        check_val({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; op = op_i; a = a_i; b = b_i; unsig = un_i;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; unsig = ~un_i; op = T_SUB;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check_val({tag, " busy_ready"}, {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, " latency"}, 64'(lat), (op_i == T_MUL) ? 64'd33 : 64'd0);
        check_val({tag, " aluout"}, {32'd0, aluout}, {32'd0, exp_r});
        check_val({tag, " compout"}, {63'd0, compout}, {63'd0, exp_c});
        check_val({tag, " overflow"}, {63'd0, overflow}, {63'd0, exp_o});
    endtask

    initial begin
        int lat8;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst aluout", {32'd0, aluout}, 64'd0);
        check_val("rst compout", {63'd0, compout}, 64'd0);
        check_val("rst overflow", {63'd0, overflow}, 64'd0);
        check_val("rst in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("post rst in_ready", {63'd0, in_ready}, 64'd1);

        run_vec("add_s_max",  T_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 1'b1);
        run_vec("add_u_wrap", T_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1);
        run_vec("add_s_m1",   T_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b1, 1'b0);
        run_vec("slt_s",      T_SLT, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b0);
        run_vec("slt_u",      T_SLT, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0);
        run_vec("sub_u",      T_SUB, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b1);
        run_vec("sub_s_ovf",  T_SUB, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_vec("and",        T_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b1, 1'b0);
        run_vec("or",         T_OR,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hFFF0FFF0, 1'b1, 1'b0);
        run_vec("xor",        T_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 1'b1, 1'b0);
        run_vec("nor",        T_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h000F000F, 1'b1, 1'b0);
        run_vec("mul_s_neg",  T_MUL, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFEB, 1'b1, 1'b0);
        run_vec("mul_u_ovf",  T_MUL, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b0, 1'b1);
        run_vec("mul_s_nn",   T_MUL, 32'hFFFFFFFC, 32'hFFFFFFFB, 1'b1, 32'h00000014, 1'b0, 1'b0);
        run_vec("mul_s_min",  T_MUL, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1, 1'b1);

        // WIDTH=8 signed multiply: 127*2 = 254 does not fit in 8-bit two's complement.
        @(negedge clk);
        check_val("w8 in_ready", {63'd0, in_ready8}, 64'd1);
        in_valid8 = 1'b1; op8 = T_MUL; a8 = 8'h7F; b8 = 8'h02; unsig8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat8 = 0;
        while (!out_valid8 && lat8 < 20) begin
            @(posedge clk);
            #1;
            lat8++;
        end
        check_val("w8 latency", 64'(lat8), 64'd9);
        check_val("w8 aluout", {56'd0, aluout8}, 64'hFE);
        check_val("w8 overflow", {63'd0, overflow8}, 64'd1);
        check_val("w8 compout", {63'd0, compout8}, 64'd0);

        // Back-pressure: result held while out_ready is low, then pop+accept back-to-back.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = T_ADD; a = 32'd5; b = 32'd6; unsig = 1'b0;
        @(posedge clk);
        #1;
        check_val("bp valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 32'd100; b = 32'd100;
            check_val("bp in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
            check_val("bp aluout", {32'd0, aluout}, 64'd11);
            check_val("bp compout", {63'd0, compout}, 64'd1);
            check_val("bp overflow", {63'd0, overflow}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; a = 32'd1; b = 32'd2;
        #1;
        check_val("pop in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        check_val("b2b1 valid", {63'd0, out_valid}, 64'd1);
        check_val("b2b1 aluout", {32'd0, aluout}, 64'd3);
        @(negedge clk);
        a = 32'd10; b = 32'd20;
        @(posedge clk);
        #1;
        check_val("b2b2 valid", {63'd0, out_valid}, 64'd1);
        check_val("b2b2 aluout", {32'd0, aluout}, 64'd30);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("drain valid", {63'd0, out_valid}, 64'd0);

        // Reset at multiply iteration 10 discards the product.
        @(negedge clk);
        in_valid = 1'b1; op = T_MUL; a = 32'd5; b = 32'd6; unsig = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midmul rst in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check_val("midmul rst valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midmul post in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_val("midmul no result", {63'd0, seen}, 64'd0);

        // Reset clears an unconsumed result.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = T_ADD; a = 32'd7; b = 32'd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("pend valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("pend cleared", {63'd0, out_valid}, 64'd0);
        check_val("pend aluout", {32'd0, aluout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
